// File: rtl/sky_pkg.sv
// Shared types and constants for the night-sky layer.
// Used by the sky cycle sequencer and the moon/star drawer.
package sky_pkg;

  typedef enum logic [1:0] {
    SKY_DAY,
    SKY_DUSK,
    SKY_NIGHT,
    SKY_DAWN
  } sky_state_t;

  localparam logic [3:0] FADE_MAX    = 4'd15;
  localparam int         STAR_COUNT  = 3;
  localparam int         MOON_PHASES = 7;

endpackage

// File: rtl/sky_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and a wrap pulse.
// Ports: clk, rst (async high), en, clr -> count, wrap (en on last value).
module sky_mod_counter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  // Wrap is combinational so the owner can act on the same edge.
  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sky_cycle_ctrl.sv
// DAY/DUSK/NIGHT/DAWN sequencer driving the moon/star sprite drawer.
// Ports: Clk, Reset, frame_tick, run, force_day -> isnight, fade_level,
//        moon_phase, star_sel, phase_advance, sky_state.
module sky_cycle_ctrl
  import sky_pkg::*;
#(
  parameter int DAY_FRAMES     = 600,
  parameter int NIGHT_FRAMES   = 400,
  parameter int FADE_STEP      = 4,
  parameter int TWINKLE_FRAMES = 10,
  parameter int NUM_PHASES     = MOON_PHASES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       force_day,
  output logic       isnight,
  output logic [3:0] fade_level,
  output logic [2:0] moon_phase,
  output logic [1:0] star_sel,
  output logic       phase_advance,
  output sky_state_t sky_state
);

  localparam int FW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam int TW = (TWINKLE_FRAMES > 1) ? $clog2(TWINKLE_FRAMES) : 1;

  sky_state_t     state;
  logic [15:0]    frame_cnt;
  logic           step;
  logic           leave;
  logic           fwrap;
  logic           twrap;
  logic           mwrap;
  logic           moon_en;
  logic [FW-1:0]  fstep_cnt;
  logic [TW-1:0]  twk_cnt;
  logic           unused_cnt;

  assign step      = frame_tick && run && !force_day;
  assign sky_state = state;
  assign isnight   = fade_level[3];

  // A fade phase ends on the fade-step wrap that would push past the end.
  always_comb begin
    leave = 1'b0;
    if (step) begin
      unique case (state)
        SKY_DAY:   leave = (frame_cnt == 16'(DAY_FRAMES - 1));
        SKY_DUSK:  leave = fwrap && (fade_level == FADE_MAX);
        SKY_NIGHT: leave = (frame_cnt == 16'(NIGHT_FRAMES - 1));
        SKY_DAWN:  leave = fwrap && (fade_level == 4'd0);
        default:   leave = 1'b0;
      endcase
    end
  end

  assign moon_en = leave && (state == SKY_DUSK);

  sky_mod_counter #(.N(FADE_STEP), .W(FW)) u_fade_step (
    .clk   (Clk),
    .rst   (Reset),
    .en    (step && (state == SKY_DUSK || state == SKY_DAWN)),
    .clr   (force_day || leave),
    .count (fstep_cnt),
    .wrap  (fwrap)
  );

  sky_mod_counter #(.N(TWINKLE_FRAMES), .W(TW)) u_twinkle (
    .clk   (Clk),
    .rst   (Reset),
    .en    (step && (state == SKY_NIGHT)),
    .clr   (force_day || leave || (state != SKY_NIGHT)),
    .count (twk_cnt),
    .wrap  (twrap)
  );

  sky_mod_counter #(.N(NUM_PHASES), .W(3)) u_moon (
    .clk   (Clk),
    .rst   (Reset),
    .en    (moon_en),
    .clr   (1'b0),
    .count (moon_phase),
    .wrap  (mwrap)
  );

  assign unused_cnt = ^{fstep_cnt, twk_cnt, mwrap};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= SKY_DAY;
      frame_cnt     <= '0;
      fade_level    <= '0;
      star_sel      <= '0;
      phase_advance <= 1'b0;
    end else if (force_day) begin
      state         <= SKY_DAY;
      frame_cnt     <= '0;
      fade_level    <= '0;
      star_sel      <= '0;
      phase_advance <= 1'b0;
    end else begin
      phase_advance <= moon_en;
      if (step) begin
        frame_cnt <= leave ? '0 : frame_cnt + 1'b1;
        unique case (state)
          SKY_DAY: begin
            if (leave) state <= SKY_DUSK;
          end
          SKY_DUSK: begin
            if (leave) begin
              state    <= SKY_NIGHT;
              star_sel <= '0;
            end else if (fwrap) begin
              fade_level <= fade_level + 1'b1;
            end
          end
          SKY_NIGHT: begin
            if (leave) begin
              state    <= SKY_DAWN;
              star_sel <= '0;
            end else if (twrap) begin
              star_sel <= (star_sel == 2'(STAR_COUNT - 1)) ?
                          '0 : star_sel + 1'b1;
            end
          end
          SKY_DAWN: begin
            if (leave) begin
              state <= SKY_DAY;
            end else if (fwrap) begin
              fade_level <= fade_level - 1'b1;
            end
          end
          default: state <= SKY_DAY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sky_cycle_ctrl.sv
// Self-checking bench for sky_cycle_ctrl: vector table fed through a
// scoreboard queue, plus hand-written async-reset corner case.
module tb_sky_cycle_ctrl;
  import sky_pkg::*;

  localparam int DF = 4;
  localparam int NF = 6;
  localparam int FS = 2;
  localparam int TF = 2;
  localparam int NP = 7;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic       force_day = 1'b0;
  logic       isnight;
  logic [3:0] fade_level;
  logic [2:0] moon_phase;
  logic [1:0] star_sel;
  logic       phase_advance;
  sky_state_t sky_state;

  sky_cycle_ctrl #(
    .DAY_FRAMES     (DF),
    .NIGHT_FRAMES   (NF),
    .FADE_STEP      (FS),
    .TWINKLE_FRAMES (TF),
    .NUM_PHASES     (NP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .run           (run),
    .force_day     (force_day),
    .isnight       (isnight),
    .fade_level    (fade_level),
    .moon_phase    (moon_phase),
    .star_sel      (star_sel),
    .phase_advance (phase_advance),
    .sky_state     (sky_state)
  );

  always #5 Clk = ~Clk;

  // exp = {state, fade, isnight, moon, star, phase_advance}
  typedef struct packed {
    logic        ft;
    logic        rn;
    logic        fd;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pa_seen  = 0;
  int row      = 0;
  int mexp     = 0;

  function automatic logic [12:0] pk(sky_state_t st, int fade, int moon,
                                     int star, bit pa);
    logic nt;
    nt = (fade >= 8);
    return {st, 4'(fade), nt, 3'(moon), 2'(star), pa};
  endfunction

  function automatic logic [12:0] act();
    return {sky_state, fade_level, isnight, moon_phase, star_sel,
            phase_advance};
  endfunction

  function automatic void add(bit ft, bit rn, bit fd, sky_state_t st,
                              int fade, int star, bit pa);
    vecs.push_back('{ft, rn, fd, pk(st, fade, mexp, star, pa)});
  endfunction

  // A step row, then an idle row: outputs hold and the pulse drops.
  function automatic void step(sky_state_t st, int fade, int star, bit pa);
    add(1'b1, 1'b1, 1'b0, st, fade, star, pa);
    add(1'b0, 1'b1, 1'b0, st, fade, star, 1'b0);
  endfunction

  function automatic void gen_day();
    for (int k = 1; k <= DF; k++)
      step((k < DF) ? SKY_DAY : SKY_DUSK, 0, 0, 1'b0);
  endfunction

  function automatic void gen_dusk(int a, int b);
    for (int k = a; k <= b; k++) begin
      if (k < 16 * FS) begin
        step(SKY_DUSK, k / FS, 0, 1'b0);
      end else begin
        mexp = (mexp + 1) % NP;
        step(SKY_NIGHT, 15, 0, 1'b1);
      end
    end
  endfunction

  function automatic void gen_night(int a, int b);
    for (int k = a; k <= b; k++) begin
      if (k < NF) step(SKY_NIGHT, 15, (k / TF) % 3, 1'b0);
      else        step(SKY_DAWN, 15, 0, 1'b0);
    end
  endfunction

  function automatic void gen_dawn(int a, int b);
    for (int k = a; k <= b; k++) begin
      if (k < 16 * FS) step(SKY_DAWN, 15 - k / FS, 0, 1'b0);
      else             step(SKY_DAY, 0, 0, 1'b0);
    end
  endfunction

  task automatic check(string name, logic [12:0] got, logic [12:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic run_vecs();
    vec_t v;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      frame_tick = v.ft;
      run        = v.rn;
      force_day  = v.fd;
      sb.push_back(v.exp);
      @(posedge Clk);
      #1;
      if (phase_advance) pa_seen++;
      row++;
      check($sformatf("row%0d", row), act(), sb.pop_front());
    end
    frame_tick = 1'b0;
    force_day  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("reset", act(), pk(SKY_DAY, 0, 0, 0, 1'b0));
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    run = 1'b1;

    // Seven full cycles: moon 1..6 then wraps to 0.
    for (int c = 0; c < NP; c++) begin
      gen_day();
      gen_dusk(1, 16 * FS);
      gen_night(1, NF);
      gen_dawn(1, 16 * FS);
    end
    run_vecs();
    check("pa_count", 13'(pa_seen), 13'(NP));

    // force_day with frame_tick mid-NIGHT; moon phase is kept.
    gen_day();
    gen_dusk(1, 16 * FS);
    gen_night(1, 3);
    add(1'b1, 1'b1, 1'b1, SKY_DAY, 0, 0, 1'b0);
    gen_day();
    run_vecs();

    // run=0 freezes mid-DUSK while frame_tick keeps pulsing.
    gen_dusk(1, 5);
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, 1'b0, SKY_DUSK, 2, 0, 1'b0);
    gen_dusk(6, 7);
    run_vecs();

    // Async reset between edges clears outputs without a clock.
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset", act(), pk(SKY_DAY, 0, 0, 0, 1'b0));
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
